// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared opcodes, control encodings, FSM states and control bundle type
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_B = 3'b101;
  localparam logic [2:0] IMM_J = 3'b110;

  localparam logic [4:0] BR_NONE = 5'b00000;
  localparam logic [4:0] BR_JUMP = 5'b10000;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_DM  = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM    = 2'b10;
  localparam logic [1:0] CAUSE_DMEM    = 2'b11;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  // Instruction class picks the FSM path taken after EXEC.
  typedef enum logic [2:0] {CL_NOP, CL_WB, CL_BRANCH, CL_LOAD, CL_STORE} cls_t;

  typedef struct packed {
    cls_t       cls;
    logic       alu_a_src;
    logic       alu_b_src;
    logic [2:0] imm_src;
    logic [3:0] alu_op;
    logic [4:0] br_op;
    logic [2:0] dm_ctrl;
    logic [1:0] ru_data_wr_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/rv32i_decoder.sv
// rtl/rv32i_decoder.sv - combinational RV32I decode of one instruction into a control bundle
module rv32i_decoder
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.cls    = CL_WB;
        ctrl.alu_op = {instr[30], funct3};
        if (funct7 != 7'b0000000 &&
            !(funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
          illegal = 1'b1;
      end
      OP_I: begin
        ctrl.cls       = CL_WB;
        ctrl.alu_b_src = 1'b1;
        ctrl.imm_src   = IMM_I;
        ctrl.alu_op    = {funct3 == 3'b101 && instr[30], funct3};
      end
      OP_LOAD: begin
        ctrl.cls            = CL_LOAD;
        ctrl.alu_b_src      = 1'b1;
        ctrl.imm_src        = IMM_I;
        ctrl.alu_op         = ALU_ADD;
        ctrl.dm_ctrl        = funct3;
        ctrl.ru_data_wr_src = WB_DM;
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        ctrl.cls       = CL_STORE;
        ctrl.alu_b_src = 1'b1;
        ctrl.imm_src   = IMM_S;
        ctrl.alu_op    = ALU_ADD;
        ctrl.dm_ctrl   = funct3;
        illegal        = funct3 > 3'b010;
      end
      OP_BRANCH: begin
        // ALU forms the PC-relative target; the branch unit does the compare.
        ctrl.cls       = CL_BRANCH;
        ctrl.alu_a_src = 1'b1;
        ctrl.alu_b_src = 1'b1;
        ctrl.imm_src   = IMM_B;
        ctrl.alu_op    = ALU_ADD;
        ctrl.br_op     = {2'b01, funct3};
        illegal        = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JAL: begin
        ctrl.cls            = CL_WB;
        ctrl.alu_a_src      = 1'b1;
        ctrl.alu_b_src      = 1'b1;
        ctrl.imm_src        = IMM_J;
        ctrl.alu_op         = ALU_ADD;
        ctrl.br_op          = BR_JUMP;
        ctrl.ru_data_wr_src = WB_PC4;
      end
      OP_JALR: begin
        ctrl.cls            = CL_WB;
        ctrl.alu_b_src      = 1'b1;
        ctrl.imm_src        = IMM_I;
        ctrl.alu_op         = ALU_ADD;
        ctrl.br_op          = BR_JUMP;
        ctrl.ru_data_wr_src = WB_PC4;
      end
      OP_LUI: begin
        ctrl.cls       = CL_WB;
        ctrl.alu_b_src = 1'b1;
        ctrl.imm_src   = IMM_U;
        ctrl.alu_op    = ALU_PASSB;
      end
      OP_AUIPC: begin
        ctrl.cls       = CL_WB;
        ctrl.alu_a_src = 1'b1;
        ctrl.alu_b_src = 1'b1;
        ctrl.imm_src   = IMM_U;
        ctrl.alu_op    = ALU_ADD;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_control.sv
// rtl/rv32i_mc_control.sv - multi-cycle RV32I control FSM with memory handshakes and trap
module rv32i_mc_control
  import rv32i_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 15,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  input  logic        dmem_ready,
  input  logic        br_taken,
  output logic        IRWr,
  output logic        PCWr,
  output logic        RUWr,
  output logic        ALUASrc,
  output logic        ALUBSrc,
  output logic        DMWr,
  output logic [1:0]  RUDataWrSrc,
  output logic [2:0]  ImmSrc,
  output logic [2:0]  DMCtrl,
  output logic [3:0]  ALUOp,
  output logic [4:0]  BrOp,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state_o
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t        state, state_n;
  logic [1:0]    cause, cause_n;
  logic [31:0]   ir;
  ctrl_t         ctrl, dec;
  logic          dec_illegal;
  logic [CW-1:0] wait_cnt;
  logic          waiting, timeout;
  logic          unused_br;

  // br_taken steers the datapath PC mux directly; the FSM pulses PCWr either way.
  assign unused_br = br_taken;

  rv32i_decoder u_decoder (
    .instr   (ir),
    .ctrl    (dec),
    .illegal (dec_illegal)
  );

  assign waiting = (state == FETCH && !imem_ready) || (state == MEM && !dmem_ready);
  // Ready in the same cycle the count saturates wins, since waiting is then low.
  assign timeout = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == CW'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      cause    <= CAUSE_NONE;
      ir       <= '0;
      ctrl     <= CTRL_NOP;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      cause <= cause_n;
      if (IRWr) ir <= instr;
      if (state == DECODE) ctrl <= dec_illegal ? CTRL_NOP : dec;
      if (waiting && !timeout) wait_cnt <= wait_cnt + 1'b1;
      else                     wait_cnt <= '0;
    end
  end

  always_comb begin
    state_n  = state;
    cause_n  = cause;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    IRWr     = 1'b0;
    PCWr     = 1'b0;
    RUWr     = 1'b0;
    DMWr     = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          IRWr    = 1'b1;
          state_n = DECODE;
        end else if (timeout) begin
          state_n = TRAP;
          cause_n = CAUSE_IMEM;
        end
      end
      DECODE: begin
        if (dec_illegal && TRAP_ILLEGAL) begin
          state_n = TRAP;
          cause_n = CAUSE_ILLEGAL;
        end else begin
          state_n = EXEC;
        end
      end
      EXEC: begin
        case (ctrl.cls)
          CL_BRANCH, CL_NOP: begin
            PCWr    = 1'b1;
            state_n = FETCH;
          end
          CL_LOAD, CL_STORE: state_n = MEM;
          default:           state_n = WB;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        DMWr     = (ctrl.cls == CL_STORE);
        if (dmem_ready) begin
          PCWr    = (ctrl.cls == CL_STORE);
          state_n = (ctrl.cls == CL_STORE) ? FETCH : WB;
        end else if (timeout) begin
          state_n = TRAP;
          cause_n = CAUSE_DMEM;
        end
      end
      WB: begin
        RUWr    = 1'b1;
        PCWr    = 1'b1;
        state_n = FETCH;
      end
      TRAP:    state_n = TRAP;
      default: state_n = FETCH;
    endcase
    // Holding everything low while rst is high stops any half-finished access leaking out.
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      IRWr     = 1'b0;
      PCWr     = 1'b0;
      RUWr     = 1'b0;
      DMWr     = 1'b0;
    end
  end

  assign ALUASrc     = !rst && ctrl.alu_a_src;
  assign ALUBSrc     = !rst && ctrl.alu_b_src;
  assign ImmSrc      = rst ? 3'b000 : ctrl.imm_src;
  assign ALUOp       = rst ? 4'b0000 : ctrl.alu_op;
  assign BrOp        = rst ? BR_NONE : ctrl.br_op;
  assign DMCtrl      = rst ? 3'b000 : ctrl.dm_ctrl;
  assign RUDataWrSrc = rst ? WB_ALU : ctrl.ru_data_wr_src;
  assign trap        = !rst && (state == TRAP);
  assign trap_cause  = rst ? CAUSE_NONE : cause;
  assign state_o     = rst ? FETCH : state;

endmodule

// File: doc/rv32i_mc_control.md
Name: rv32i_mc_control

Overview:
- Multi-cycle successor to the single-cycle RV32I control decoder.
- A registered FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Talks to instruction and data memory over req/ready handshakes, with a wait-state timeout.
- Emits the same datapath control bundle, plus IR/PC write strobes and an illegal-instruction/timeout trap. Sits between the memories and the datapath in the multi-cycle core.
- Fixes decode gaps: SRAI vs SRLI by instr[30]; adds JALR, LUI, AUIPC.

Parameters:
- MEM_TIMEOUT, 15: max cycles a req may wait for ready before trapping; 0 disables the timeout.
- TRAP_ILLEGAL, 1: 1 = unknown opcode/funct traps; 0 = unknown opcode executes as NOP.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- instr  in  32  instruction read data, valid when imem_ready=1
- imem_req  out  1  fetch request, held until imem_ready
- imem_ready  in  1  fetch complete
- dmem_req  out  1  load/store request, held until dmem_ready
- dmem_ready  in  1  data access complete
- br_taken  in  1  branch-unit compare result, sampled in EXEC
- IRWr  out  1  latch instr into IR
- PCWr  out  1  PC update strobe
- RUWr, ALUASrc, ALUBSrc, DMWr  out  1 each  datapath controls
- RUDataWrSrc  out  2  00 ALU, 01 DM, 10 PC+4
- ImmSrc  out  3  I 000, S 001, U 010, B 101, J 110
- DMCtrl  out  3  funct3 of the load/store
- ALUOp  out  4  ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, PASSB 1001
- BrOp  out  5  00000 none, {01,funct3} branch, 10000 jump
- trap  out  1  sticky trap flag
- trap_cause  out  2  01 illegal, 10 imem timeout, 11 dmem timeout
- state_o  out  3  current state, for debug

Behaviour:
- Reset: every output is 0, state=FETCH, wait counter=0, decoded bundle cleared.
  - rst mid-instruction aborts it; req drops the cycle after rst.
  - No partial RUWr/DMWr/PCWr may be issued after rst.
- FETCH: imem_req=1 until imem_ready.
  - On ready: IRWr=1 for one cycle, then go to DECODE.
- DECODE: sub-module output registered into the control bundle.
  - Illegal encoding with TRAP_ILLEGAL=1 → TRAP, cause 01.
- EXEC: bundle drives the ALU.
  - Branch: PCWr=1 (next PC selected by BrOp/br_taken), then FETCH.
  - JAL/JALR: go to WB, which writes PC+4 and asserts PCWr.
  - Load/store: go to MEM.
  - R/I/LUI/AUIPC: go to WB.
- MEM: dmem_req=1 and DMWr=1 (store), held until dmem_ready.
  - Load → WB.
  - Store → PCWr=1 in the ready cycle, then FETCH.
- WB: RUWr=1 and PCWr=1 for exactly one cycle, then FETCH.
- TRAP: all strobes 0, trap=1; held until rst.
- Cycle counts with zero-wait memory (ready in the request cycle):
  - branch 3
  - store 4
  - R/I/U/jump 4
  - load 5
  - Each wait cycle adds 1.
- Wait counter: width $clog2(MEM_TIMEOUT+1).
  - Counts while req=1 and ready=0; clears on ready.
  - Reaching MEM_TIMEOUT → TRAP (cause 10 or 11), req dropped.
  - ready arriving in the same cycle as the counter reaching MEM_TIMEOUT counts as success.
- Strobes: PCWr, IRWr, RUWr and DMWr are never asserted together with trap. PCWr pulses exactly once per retired instruction.
- Decode rules:
  - SRAI when funct3=101 and instr[30]=1; SRLI otherwise.
  - Non-zero funct7 on R-type, other than 0100000 with ADD/SRL (i.e. SUB/SRA), is illegal.
  - Load funct3 in {011,110,111} is illegal.
  - Store funct3 > 010 is illegal.
  - Branch funct3 in {010,011} is illegal.
  - JALR: ImmSrc I, ALUBSrc=1, BrOp=10000, RUDataWrSrc=10.
  - LUI: ImmSrc U, ALUOp PASSB.
  - AUIPC: ALUASrc=1, ALUBSrc=1, ADD.

Decomposition:
- Package rv32i_pkg holds:
  - opcode localparams
  - ALUOp, ImmSrc, BrOp, RUDataWrSrc and trap_cause constants
  - state enum (FETCH, DECODE, EXEC, MEM, WB, TRAP)
  - packed struct ctrl_t for the control bundle
- One combinational sub-module, rv32i_decoder: instr → ctrl_t plus illegal flag.
- The FSM, counter and handshakes live in rv32i_mc_control.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), imem_ready tied 1 → IRWr at cycle 1, RUWr=PCWr=1 at cycle 4, ALUOp=0000.
- SRAI x5,x5,3 (0x4032D293) → ALUOp=1101; SRLI (0x0032D293) → ALUOp=0101.
- LW with dmem_ready delayed 3 cycles → dmem_req held 4 cycles, RUDataWrSrc=01, RUWr in cycle 8.
- BEQ (0x00208463), br_taken=1 → BrOp=01000, PCWr in cycle 3, no RUWr.
- imem_ready held 0, MEM_TIMEOUT=15 → trap=1, trap_cause=10 after 15 wait cycles, imem_req drops.
- Opcode 0x7F → trap cause 01. rst asserted during MEM → next cycle dmem_req=0, state_o=FETCH, all strobes 0.
